audio_sample_fifo: RTL and testbench

- Buffers 32-bit stereo audio samples between the monitor-link receive path (opcode decoder, audio-data strobe) and the I2S sender.
- Generates the audio-request pulse toward the opcode encoder, so the host sends more samples in bursts before the buffer drains.
- Single clock domain (mon_clk). The I2S sender pops samples in mon_clk.

---
 rtl/audio_sample_fifo_if.sv | 22 ++
 rtl/audio_sample_fifo.sv | 76 +++++++
 tb/tb_audio_sample_fifo.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/audio_sample_fifo_if.sv
// audio_sample_fifo_if: sample push/pop handshake, request pulse and status between link decoder, I2S sender and FIFO
// master drives audio_en, in_valid/in_data and out_ready; slave (the FIFO) returns data, request and status.
interface audio_sample_fifo_if #(parameter int AW = 4);
    logic          audio_en;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          audio_req;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;
    modport master (
        output audio_en, in_valid, in_data, out_ready,
        input  out_data, out_valid, audio_req, level, overflow, underflow
    );
    modport slave (
        input  audio_en, in_valid, in_data, out_ready,
        output out_data, out_valid, audio_req, level, overflow, underflow
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: show-ahead stereo sample buffer with burst audio-request generation
// mon_clk/reset: clock and synchronous active-high reset.
// bus.audio_en enables requests; in_valid/in_data push; out_ready pops;
// out_data/out_valid show the head; audio_req pulses one cycle; level, overflow, underflow report status.
module audio_sample_fifo #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 4095
) (
    input logic mon_clk,
    input logic reset,
    audio_sample_fifo_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] REQ_MAX = (AW+1)'(DEPTH - BURST);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   level, burst_cnt, burst_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          push, pop, audio_req, overflow, underflow;
    state_t        state;
    // A full FIFO still accepts a push when the same cycle pops the head.
    assign pop       = bus.out_ready && level != '0;
    assign push      = bus.in_valid && (level != FULL || pop);
    assign burst_nxt = burst_cnt - {{AW{1'b0}}, push};
    assign tmo_nxt   = tmo_cnt - TW'(1);
    always_ff @(posedge mon_clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            state     <= IDLE;
            audio_req <= 1'b0;
            burst_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level     <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            overflow  <= overflow | (bus.in_valid & ~push);
            underflow <= underflow | (bus.out_ready & (level == '0));
            audio_req <= 1'b0;
            case (state)
                IDLE: if (bus.audio_en && level <= REQ_MAX) begin
                    state     <= REQ;
                    audio_req <= 1'b1;
                end
                REQ: begin
                    burst_cnt <= (AW+1)'(BURST);
                    tmo_cnt   <= TW'(TIMEOUT);
                    state     <= WAIT;
                end
                WAIT: begin
                    burst_cnt <= burst_nxt;
                    tmo_cnt   <= tmo_nxt;
                    if (burst_nxt == '0 || tmo_nxt == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.level     = level;
    assign bus.out_valid = level != '0;
    assign bus.out_data  = level != '0 ? mem[rd_ptr] : '0;
    assign bus.audio_req = audio_req;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed and randomized checks of audio_sample_fifo against a queue-based model
module tb_audio_sample_fifo;
    logic mon_clk = 1'b0;
    logic reset = 1'b1;
    always #5 mon_clk = ~mon_clk;
    audio_sample_fifo_if bus ();
    audio_sample_fifo dut (.mon_clk(mon_clk), .reset(reset), .bus(bus.slave));
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [31:0] q[$];
    bit m_ovf, m_unf, m_req;
    int ph, left, tmo;
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction
    // Model: queue holds contents; ph 0 = waiting for room, 1 = request cycle, 2 = burst outstanding.
    always @(posedge mon_clk) begin : model
        int n;
        bit po, pu;
        n = q.size();
        if (reset) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_req = 0; ph = 0;
        end else begin
            po = bus.out_ready && n > 0;
            pu = bus.in_valid && (n < 16 || po);
            m_unf |= bus.out_ready && n == 0;
            m_ovf |= bus.in_valid && !pu;
            m_req = 0;
            if (ph == 0) begin
                if (bus.audio_en && 16 - n >= 4) begin ph = 1; m_req = 1; end
            end else if (ph == 1) begin
                left = 4; tmo = 4095; ph = 2;
            end else begin
                left -= int'(pu);
                tmo--;
                if (left == 0 || tmo == 0) ph = 0;
            end
            if (po) void'(q.pop_front());
            if (pu) q.push_back(bus.in_data);
        end
    end
    always @(negedge mon_clk) begin
        if (chk_en) begin
            chk("level", 32'(bus.level), q.size());
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            chk("out_data", bus.out_data, q.size() > 0 ? q[0] : 32'h0);
            chk("audio_req", 32'(bus.audio_req), 32'(m_req));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("underflow", 32'(bus.underflow), 32'(m_unf));
        end
    end
    task automatic cyc(bit r, bit en, bit iv, logic [31:0] d, bit rdy);
        reset = r;
        bus.audio_en = en;
        bus.in_valid = iv;
        bus.in_data = d;
        bus.out_ready = rdy;
        @(negedge mon_clk);
        #1;
    endtask
    initial begin
        int n;
        cyc(1, 1, 0, 0, 0);
        chk_en = 1'b1;
        cyc(1, 1, 0, 0, 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_req", 32'(bus.audio_req), 0);
        cyc(0, 1, 0, 0, 0);
        chk("first_req", 32'(bus.audio_req), 1);
        cyc(0, 1, 0, 0, 0);
        chk("req_one_cycle", 32'(bus.audio_req), 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 32'h11110000 + i, 0);
        chk("burst_level", 32'(bus.level), 4);
        cyc(0, 1, 0, 0, 0);
        chk("req_after_burst", 32'(bus.audio_req), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("pop_order", bus.out_data, 32'h11110000 + i);
            cyc(0, 1, 0, 0, 1);
        end
        chk("drained_data", bus.out_data, 0);
        chk("drained_valid", 32'(bus.out_valid), 0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 1, 32'h20000000 + i, 0);
        chk("full_level", 32'(bus.level), 16);
        cyc(0, 1, 1, 32'hDEADBEEF, 0);
        chk("ovf_flag", 32'(bus.overflow), 1);
        chk("ovf_level", 32'(bus.level), 16);
        cyc(0, 1, 1, 32'hCAFE0000, 1);
        chk("full_pushpop_level", 32'(bus.level), 16);
        for (int i = 1; i < 16; i++) begin
            chk("full_drain", bus.out_data, 32'h20000000 + i);
            cyc(0, 1, 0, 0, 1);
        end
        chk("tail_sample", bus.out_data, 32'hCAFE0000);
        cyc(0, 1, 0, 0, 1);
        chk("empty_again", 32'(bus.level), 0);
        cyc(1, 0, 0, 0, 0);
        chk("ovf_cleared", 32'(bus.overflow), 0);
        cyc(0, 0, 0, 0, 1);
        chk("unf_flag", 32'(bus.underflow), 1);
        chk("unf_level", 32'(bus.level), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'h55AA55AA, 1);
        chk("empty_pushpop_level", 32'(bus.level), 1);
        chk("empty_pushpop_unf", 32'(bus.underflow), 1);
        chk("empty_pushpop_data", bus.out_data, 32'h55AA55AA);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("tmo_first_req", 32'(bus.audio_req), 1);
        n = 0;
        do begin
            cyc(0, 1, 0, 0, 0);
            n++;
        end while (!bus.audio_req && n < 5000);
        chk("tmo_gap", n, 4097);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 32'h30000000 + i, 0);
        chk("wait_level", 32'(bus.level), 7);
        cyc(1, 1, 0, 0, 0);
        chk("midrst_level", 32'(bus.level), 0);
        chk("midrst_req", 32'(bus.audio_req), 0);
        chk("midrst_flags", {bus.overflow, bus.underflow}, 0);
        cyc(0, 1, 0, 0, 0);
        chk("midrst_next_req", 32'(bus.audio_req), 1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(199) == 0, $urandom_range(7) != 0, $urandom_range(1) == 1,
                $urandom, $urandom_range(4) < 2);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
